// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: two-port D-cache arbiter, one outstanding transaction, starvation guard for port 1
module dcache_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        p0_req_valid_i,
  input  logic [31:0] p0_req_addr_i,
  input  logic        p0_req_rw_i,
  input  logic [1:0]  p0_req_size_i,
  input  logic [31:0] p0_req_wdata_i,
  input  logic        p0_req_uncached_i,
  output logic        p0_req_acc_o,
  output logic        p0_rsp_valid_o,
  output logic [31:0] p0_rsp_data_o,
  input  logic        p1_req_valid_i,
  input  logic [31:0] p1_req_addr_i,
  input  logic        p1_req_rw_i,
  input  logic [1:0]  p1_req_size_i,
  input  logic [31:0] p1_req_wdata_i,
  input  logic        p1_req_uncached_i,
  output logic        p1_req_acc_o,
  output logic        p1_rsp_valid_o,
  output logic [31:0] p1_rsp_data_o,
  output logic        dc_req_valid_o,
  output logic [31:0] dc_req_addr_o,
  output logic        dc_req_rw_o,
  output logic [1:0]  dc_req_size_o,
  output logic [31:0] dc_req_wdata_o,
  output logic        dc_req_uncached_o,
  input  logic        dc_rsp_valid_i,
  input  logic [31:0] dc_rsp_data_i,
  output logic        busy_o
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       drop_q, drop_d;
  logic       owner_q;
  logic       win1, grant, issue, rsp;
  assign win1  = p1_req_valid_i && (!p0_req_valid_i || starve_q == LIM);
  assign grant = state_q == IDLE && (p0_req_valid_i || p1_req_valid_i) && !flush_i;
  assign issue = state_q == ISSUE && !flush_i;
  // a response that races a flush is dropped just like one after it
  assign rsp   = state_q == WAIT && dc_rsp_valid_i && !(drop_q || flush_i);
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        state_d  = grant ? ISSUE : IDLE;
        starve_d = flush_i ? starve_q
                 : (!p1_req_valid_i || win1) ? 4'd0
                 : (starve_q < LIM) ? starve_q + 4'd1 : starve_q;
      end
      ISSUE: state_d = flush_i ? IDLE : WAIT;
      WAIT: begin
        state_d = dc_rsp_valid_i ? IDLE : WAIT;
        drop_d  = dc_rsp_valid_i ? 1'b0 : (drop_q || flush_i);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      starve_q          <= '0;
      drop_q            <= 1'b0;
      owner_q           <= 1'b0;
      dc_req_addr_o     <= '0;
      dc_req_rw_o       <= 1'b0;
      dc_req_size_o     <= '0;
      dc_req_wdata_o    <= '0;
      dc_req_uncached_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      if (grant) begin
        owner_q           <= win1;
        dc_req_addr_o     <= win1 ? p1_req_addr_i     : p0_req_addr_i;
        dc_req_rw_o       <= win1 ? p1_req_rw_i       : p0_req_rw_i;
        dc_req_size_o     <= win1 ? p1_req_size_i     : p0_req_size_i;
        dc_req_wdata_o    <= win1 ? p1_req_wdata_i    : p0_req_wdata_i;
        dc_req_uncached_o <= win1 ? p1_req_uncached_i : p0_req_uncached_i;
      end
    end
  end
  assign dc_req_valid_o = issue;
  assign p0_req_acc_o   = issue && !owner_q;
  assign p1_req_acc_o   = issue && owner_q;
  assign p0_rsp_valid_o = rsp && !owner_q;
  assign p1_rsp_valid_o = rsp && owner_q;
  assign p0_rsp_data_o  = p0_rsp_valid_o ? dc_rsp_data_i : '0;
  assign p1_rsp_data_o  = p1_rsp_valid_o ? dc_rsp_data_i : '0;
  assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed, self-checking bench for dcache_port_arbiter
module tb_dcache_port_arbiter;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic p0_v = 0, p0_rw = 0, p0_unc = 0, p1_v = 0, p1_rw = 0, p1_unc = 0;
  logic [31:0] p0_addr = 0, p0_wd = 0, p1_addr = 0, p1_wd = 0, rsp_data = 0;
  logic [1:0] p0_sz = 0, p1_sz = 0;
  logic rsp_v = 0;
  logic p0_acc, p0_rv, p1_acc, p1_rv, dc_v, dc_rw, dc_unc, busy;
  logic [31:0] p0_rd, p1_rd, dc_addr, dc_wd;
  logic [1:0] dc_sz;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  dcache_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .p0_req_valid_i(p0_v), .p0_req_addr_i(p0_addr), .p0_req_rw_i(p0_rw), .p0_req_size_i(p0_sz),
    .p0_req_wdata_i(p0_wd), .p0_req_uncached_i(p0_unc), .p0_req_acc_o(p0_acc),
    .p0_rsp_valid_o(p0_rv), .p0_rsp_data_o(p0_rd),
    .p1_req_valid_i(p1_v), .p1_req_addr_i(p1_addr), .p1_req_rw_i(p1_rw), .p1_req_size_i(p1_sz),
    .p1_req_wdata_i(p1_wd), .p1_req_uncached_i(p1_unc), .p1_req_acc_o(p1_acc),
    .p1_rsp_valid_o(p1_rv), .p1_rsp_data_o(p1_rd),
    .dc_req_valid_o(dc_v), .dc_req_addr_o(dc_addr), .dc_req_rw_o(dc_rw), .dc_req_size_o(dc_sz),
    .dc_req_wdata_o(dc_wd), .dc_req_uncached_o(dc_unc),
    .dc_rsp_valid_i(rsp_v), .dc_rsp_data_i(rsp_data), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " dc_v"}, 32'(dc_v), 0);
    chk({tag, " dc_addr"}, dc_addr, 0);
    chk({tag, " dc_wd"}, dc_wd, 0);
    chk({tag, " ctl"}, {27'd0, dc_rw, dc_sz, dc_unc}, 0);
    chk({tag, " acc"}, {30'd0, p0_acc, p1_acc}, 0);
    chk({tag, " rv"}, {30'd0, p0_rv, p1_rv}, 0);
    chk({tag, " p0_rd"}, p0_rd, 0);
    chk({tag, " p1_rd"}, p1_rd, 0);
  endtask
  initial begin
    // reset
    tick(); tick();
    rsp_v = 1; rsp_data = 32'h1111_1111;
    #1 chk_all_zero("reset");
    tick(); rst = 0; rsp_v = 0;
    // port 0 load, response three cycles after the request
    p0_v = 1; p0_addr = 32'h100; p0_sz = 2;
    #1 chk("ld idle dc_v", 32'(dc_v), 0);
    tick(); p0_v = 0;
    #1 chk("ld issue dc_v", 32'(dc_v), 1);
    chk("ld issue addr", dc_addr, 32'h100);
    chk("ld issue acc", {30'd0, p0_acc, p1_acc}, 2);
    tick();
    #1 chk("ld wait busy", 32'(busy), 1);
    chk("ld wait dc_v", 32'(dc_v), 0);
    tick(); rsp_v = 1; rsp_data = 32'hDEAD_BEEF;
    #1 chk("ld rsp valid", {30'd0, p0_rv, p1_rv}, 2);
    chk("ld rsp data", p0_rd, 32'hDEAD_BEEF);
    chk("ld p1 data", p1_rd, 0);
    tick(); rsp_v = 0;
    #1 chk("ld idle busy", 32'(busy), 0);
    // starvation: both request continuously, single-cycle cache
    p0_v = 1; p0_addr = 32'h1000; p1_v = 1; p1_addr = 32'h2000;
    rsp_v = 1; rsp_data = 32'h0000_00AB;
    for (int g = 0; g < 10; g++) begin
      tick();
      #1 chk($sformatf("starve g%0d acc", g), {30'd0, p0_acc, p1_acc}, (g == 8) ? 1 : 2);
      chk($sformatf("starve g%0d addr", g), dc_addr, (g == 8) ? 32'h2000 : 32'h1000);
      tick();
      #1 chk($sformatf("starve g%0d rv", g), {30'd0, p0_rv, p1_rv}, (g == 8) ? 1 : 2);
      tick();
    end
    p0_v = 0; p1_v = 0; rsp_v = 0;
    // port 1 uncached half store
    p1_v = 1; p1_addr = 32'h204; p1_rw = 1; p1_sz = 1; p1_wd = 32'h55AA; p1_unc = 1;
    tick(); p1_v = 0;
    #1 chk("st dc_v", 32'(dc_v), 1);
    chk("st addr", dc_addr, 32'h204);
    chk("st wdata", dc_wd, 32'h55AA);
    chk("st ctl", {27'd0, dc_rw, dc_sz, dc_unc}, 32'b1_01_1);
    chk("st acc", {30'd0, p0_acc, p1_acc}, 1);
    tick(); rsp_v = 1; rsp_data = 32'h1234;
    #1 chk("st one cycle", 32'(dc_v), 0);
    chk("st rsp valid", {30'd0, p0_rv, p1_rv}, 1);
    chk("st rsp data", p1_rd, 32'h1234);
    chk("st p0 data", p0_rd, 0);
    tick(); rsp_v = 0;
    // flush during WAIT, response two cycles later
    p0_v = 1; p0_addr = 32'h300; p0_rw = 0; p0_sz = 2;
    tick(); p0_v = 0;
    tick(); flush = 1;
    #1 chk("fw busy", 32'(busy), 1);
    tick(); flush = 0;
    tick(); rsp_v = 1; rsp_data = 32'h7777;
    #1 chk("fw rsp dropped", {30'd0, p0_rv, p1_rv}, 0);
    chk("fw busy at rsp", 32'(busy), 1);
    tick(); rsp_v = 0;
    #1 chk("fw busy after", 32'(busy), 0);
    p0_v = 1; p0_addr = 32'h304;
    tick(); p0_v = 0;
    #1 chk("fw next acc", {30'd0, p0_acc, p1_acc}, 2);
    chk("fw next addr", dc_addr, 32'h304);
    tick(); rsp_v = 1; rsp_data = 32'hCAFE;
    #1 chk("fw next rsp", {30'd0, p0_rv, p1_rv}, 2);
    chk("fw next data", p0_rd, 32'hCAFE);
    tick(); rsp_v = 0;
    // reset during WAIT, stale response the next cycle
    p0_v = 1; p0_addr = 32'h400;
    tick(); p0_v = 0;
    tick(); rst = 1;
    tick(); rst = 0; rsp_v = 1; rsp_data = 32'hBAD;
    #1 chk_all_zero("rst wait");
    tick(); rsp_v = 0;
    #1 chk("rst stays idle", 32'(busy), 0);
    // flush in ISSUE
    p0_v = 1; p0_addr = 32'h500;
    tick(); flush = 1; p0_v = 0;
    #1 chk("fi dc_v", 32'(dc_v), 0);
    chk("fi acc", {30'd0, p0_acc, p1_acc}, 0);
    tick(); flush = 0;
    #1 chk("fi busy", 32'(busy), 0);
    // flush in IDLE blocks the grant for that cycle only
    p0_v = 1; p0_addr = 32'h600; flush = 1;
    tick(); flush = 0;
    #1 chk("fidle blocked", 32'(busy), 0);
    tick(); p0_v = 0;
    #1 chk("fidle grant acc", {30'd0, p0_acc, p1_acc}, 2);
    chk("fidle grant addr", dc_addr, 32'h600);
    tick(); rsp_v = 1; rsp_data = 32'h6;
    #1 chk("fidle rsp", p0_rd, 32'h6);
    tick(); rsp_v = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, giving the consecutive port-1 losses before port 1 takes priority (range 1..15).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1, pipeline flush or fence.i.
REQ-005 SHALL have ports pN_req_valid_i, input, 1 (N=0,1); port 0 is the load/store buffer and port 1 is the auxiliary requester.
REQ-006 SHALL have ports pN_req_addr_i, input, 32, byte address.
REQ-007 SHALL have ports pN_req_rw_i, input, 1, where 1 = store.
REQ-008 SHALL have ports pN_req_size_i, input, 2, where 0 = BYTE, 1 = HALF, 2 = WORD.
REQ-009 SHALL have ports pN_req_wdata_i, input, 32, store data.
REQ-010 SHALL have ports pN_req_uncached_i, input, 1, the PMA uncached flag.
REQ-011 SHALL have ports pN_req_acc_o, output, 1, a one-cycle accept pulse.
REQ-012 SHALL have ports pN_rsp_valid_o, output, 1, a one-cycle response pulse.
REQ-013 SHALL have ports pN_rsp_data_o, output, 32, the raw D-cache word.
REQ-014 SHALL have ports dc_req_valid_o, output, 1; dc_req_addr_o, output, 32; dc_req_rw_o, output, 1; dc_req_size_o, output, 2; dc_req_wdata_o, output, 32; and dc_req_uncached_o, output, 1. Together these form the D-cache request.
REQ-015 SHALL have ports dc_rsp_valid_i, input, 1, and dc_rsp_data_i, input, 32, the D-cache response.
REQ-016 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ISSUE and WAIT.
REQ-018 In IDLE with any pN_req_valid_i high, SHALL select a winner, latch its addr, rw, size, wdata and uncached plus the owner id, and enter ISSUE.
REQ-019 Arbitration SHALL be fixed priority to port 0, except that port 1 wins when starve_cnt == STARVE_LIMIT.
REQ-020 starve_cnt (4-bit) SHALL increment, saturating at STARVE_LIMIT, when both ports request in IDLE and port 0 wins; it SHALL clear when port 1 wins or when port 1 is not requesting in IDLE.
REQ-021 In ISSUE, SHALL drive dc_req_valid_o=1 for exactly one cycle with the latched payload, pulse pOwner_req_acc_o in the same cycle, and enter WAIT.
REQ-022 dc_req_* payload outputs SHALL always reflect the latched payload.
REQ-023 In WAIT, on dc_rsp_valid_i, SHALL drive pOwner_rsp_valid_o=1 and pOwner_rsp_data_o=dc_rsp_data_i in the same cycle (combinational), then enter IDLE.
REQ-024 The non-owner rsp_valid SHALL be 0 at all times.
REQ-025 The non-owner rsp_data SHALL be 0.
REQ-026 Latency: request seen in IDLE at cycle t gives dc_req_valid_o and acc at t+1; the response is forwarded in the same cycle it arrives, at no earlier than t+2.
REQ-027 At most one D-cache transaction SHALL be outstanding.
REQ-028 After a response, at least one IDLE cycle SHALL occur before the next ISSUE.
REQ-029 Requesters SHALL hold pN_req_* stable until acc.
REQ-030 A requester deasserting valid before acc SHALL be a legal withdrawal while in IDLE.
REQ-031 flush_i in IDLE SHALL block any grant that cycle.
REQ-032 flush_i in ISSUE SHALL suppress dc_req_valid_o and acc, and return the FSM to IDLE.
REQ-033 flush_i in WAIT SHALL set drop_q; the FSM keeps waiting, and the response, when it arrives, is consumed with rsp_valid suppressed; drop_q clears on leaving WAIT.
REQ-034 flush_i SHALL NOT clear starve_cnt.
REQ-035 dc_rsp_valid_i outside WAIT SHALL be ignored.

Reset
REQ-036 rst_i high SHALL, at the next edge, set the state to IDLE and clear starve_cnt, drop_q, the latched payload and the owner id, regardless of state, including mid-WAIT.
REQ-037 During and after reset, all outputs SHALL be 0 until a new grant.
REQ-038 A dc_rsp_valid_i arriving after a mid-WAIT reset SHALL be ignored.

Verification
REQ-039 Port 0 requests a load at addr 0x100 in IDLE; the cache responds at t+3 with 0xDEADBEEF -> dc_req_valid_o=1 at t+1 with addr 0x100; p0_req_acc_o at t+1; p0_rsp_valid_o=1 with data 0xDEADBEEF at t+3; p1 outputs stay 0.
REQ-040 Both ports request continuously, STARVE_LIMIT=8, single-cycle cache -> port 0 wins 8 grants, the 9th grant goes to port 1, and starve_cnt returns to 0.
REQ-041 Port 1 issues a store of 0x55AA to 0x204 with size=HALF and uncached=1 -> dc_req shows rw=1, size=1, wdata 0x55AA, uncached=1 for exactly one cycle.
REQ-042 flush_i is asserted during WAIT and the response arrives 2 cycles later -> no rsp_valid to either port, busy_o drops the cycle after the response, and the next request is serviced normally.
REQ-043 rst_i is asserted during WAIT and a stale dc_rsp_valid_i arrives the next cycle -> all outputs stay 0 and the state stays IDLE.
REQ-044 flush_i is asserted in the ISSUE cycle -> dc_req_valid_o=0, no acc, and busy_o=0 the following cycle.
